// File: rtl/ab_stim_seq.sv
// ab_stim_seq
// Clocked stimulus sequencer and response checker for a two-input/one-output
// logic cell whose expected behaviour is c = a | b. It walks the fixed vector
// table (a,b) = 11, 10, 01, 00, holds each vector for HOLD_CYCLES cycles,
// samples the cell response on the last cycle of each hold window and keeps a
// saturating mismatch count for the run.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     level-sampled run request, accepted only while idle
//   c_in      response from the cell under check
//   a_out     stimulus a to the cell
//   b_out     stimulus b to the cell
//   busy      high while vectors are being driven
//   vec_idx   index of the vector currently driven (0..3)
//   mismatch  one-cycle pulse when a sampled response is wrong
//   err_cnt   saturating mismatch count of the current or last run
//   done      one-cycle pulse at the end of a run
//   pass      high when the last completed run had no mismatches

module ab_stim_seq #(
    parameter int HOLD_CYCLES = 5,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             c_in,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic [1:0]       vec_idx,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt,
    output logic             done,
    output logic             pass
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;
    localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

    state_t           state, next_state;
    logic [7:0]       hold, hold_nxt;
    logic [1:0]       vec_nxt, vec_plus;
    logic             a_nxt, b_nxt, busy_nxt, mism_nxt, done_nxt, pass_nxt;
    logic [ERR_W-1:0] err_nxt, err_inc;
    logic             sample_miss;

    // State and every registered output live in one register block so that
    // an asynchronous reset clears them all together, aborting any run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold     <= '0;
            vec_idx  <= '0;
            a_out    <= 1'b0;
            b_out    <= 1'b0;
            busy     <= 1'b0;
            mismatch <= 1'b0;
            err_cnt  <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            state    <= next_state;
            hold     <= hold_nxt;
            vec_idx  <= vec_nxt;
            a_out    <= a_nxt;
            b_out    <= b_nxt;
            busy     <= busy_nxt;
            mismatch <= mism_nxt;
            err_cnt  <= err_nxt;
            done     <= done_nxt;
            pass     <= pass_nxt;
        end
    end

    // Next-state and next-output logic. The vector table is encoded by the
    // index itself: a = ~idx[1], b = ~idx[0] gives 11, 10, 01, 00, and the
    // expected response a | b is therefore 1 for every index except 3.
    always_comb begin
        next_state  = state;
        hold_nxt    = hold;
        vec_nxt     = vec_idx;
        a_nxt       = a_out;
        b_nxt       = b_out;
        busy_nxt    = busy;
        mism_nxt    = 1'b0;
        err_nxt     = err_cnt;
        done_nxt    = 1'b0;
        pass_nxt    = pass;
        sample_miss = 1'b0;
        err_inc     = err_cnt;
        vec_plus    = vec_idx + 2'd1;

        case (state)
            IDLE: begin
                a_nxt = 1'b0;
                b_nxt = 1'b0;
                if (start) begin
                    next_state = DRIVE;
                    hold_nxt   = '0;
                    vec_nxt    = 2'd0;
                    a_nxt      = 1'b1;
                    b_nxt      = 1'b1;
                    busy_nxt   = 1'b1;
                    err_nxt    = '0;
                    pass_nxt   = 1'b0;
                end
            end

            DRIVE: begin
                if (hold == HOLD_LAST) begin
                    sample_miss = (c_in != (vec_idx != 2'd3));
                    // Saturate instead of wrapping so a narrow counter never
                    // reads back as zero after enough failures.
                    if (sample_miss && (err_cnt != ERR_MAX)) begin
                        err_inc = err_cnt + ERR_ONE;
                    end
                    mism_nxt = sample_miss;
                    err_nxt  = err_inc;
                    hold_nxt = '0;
                    if (vec_idx != 2'd3) begin
                        vec_nxt = vec_plus;
                        a_nxt   = ~vec_plus[1];
                        b_nxt   = ~vec_plus[0];
                    end else begin
                        // Last vector: pass must include a miss found on this
                        // very edge, hence err_inc rather than err_cnt.
                        next_state = FIN;
                        a_nxt      = 1'b0;
                        b_nxt      = 1'b0;
                        busy_nxt   = 1'b0;
                        done_nxt   = 1'b1;
                        pass_nxt   = (err_inc == '0);
                    end
                end else begin
                    hold_nxt = hold + 8'd1;
                end
            end

            FIN: begin
                next_state = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: doc/ab_stim_seq.md
Name: ab_stim_seq

Overview:
- Synthesizable stimulus sequencer and response checker for the two-input/one-output `simple`-style logic cells (inputs a, b; output c).
- Drives the fixed four-vector a/b sequence and holds each vector for a programmable number of cycles.
- Samples the cell's c response at the end of each hold window and compares it against the expected c = a | b.
- Replaces delay-based testbench stimulus with a clocked driver that can sit next to the cell in hardware.

Parameters:
- HOLD_CYCLES, 5, cycles each vector is held on a_out/b_out; legal range 2..255.
- ERR_W, 8, width of the saturating mismatch counter; legal range 1..16.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level-sampled request; accepted only in IDLE.
- c_in  input  1  response from the cell under check.
- a_out  output  1  stimulus a to the cell.
- b_out  output  1  stimulus b to the cell.
- busy  output  1  high while vectors are being driven.
- vec_idx  output  2  index of the vector currently driven (0..3).
- mismatch  output  1  one-cycle pulse when a sampled c_in differs from expected.
- err_cnt  output  ERR_W  saturating count of mismatches in the current or last run.
- done  output  1  one-cycle pulse at the end of a run.
- pass  output  1  high when the last completed run had err_cnt == 0.

Behaviour:
- Vector table, fixed (a,b): idx0 = (1,1), idx1 = (1,0), idx2 = (0,1), idx3 = (0,0).
- Expected c per vector: 1, 1, 1, 0.
- Reset (rst_n low, asynchronous): state = IDLE; a_out = b_out = 0; busy = 0; vec_idx = 0; mismatch = 0; err_cnt = 0; done = 0; pass = 0; hold counter = 0.
- Reset asserted mid-run aborts the run immediately: outputs go to reset values with no done pulse.
- FSM states: IDLE, DRIVE, FIN.
- IDLE, start == 1 at an edge:
  - go to DRIVE;
  - a_out/b_out = vector 0, vec_idx = 0, hold = 0, busy = 1, err_cnt = 0, pass = 0.
- IDLE, start == 0: outputs hold; a_out = b_out = 0.
- DRIVE, each edge with hold < HOLD_CYCLES-1: hold increments; vectors unchanged.
- DRIVE, edge with hold == HOLD_CYCLES-1 (sample edge):
  - c_in is sampled and compared with the expected c for vec_idx;
  - mismatch is registered high for exactly one cycle if they differ;
  - err_cnt increments, saturating at 2^ERR_W - 1;
  - if vec_idx < 3: vec_idx increments, the next vector is applied, hold = 0;
  - if vec_idx == 3: go to FIN; a_out = b_out = 0; busy = 0; done = 1; pass = (final err_cnt == 0), including a mismatch detected at this same edge.
- FIN: lasts exactly one cycle.
  - Next edge: done = 0 and state = IDLE.
  - err_cnt, pass and vec_idx (= 3) are held until the next accepted start.
- Timing:
  - Each vector is held exactly HOLD_CYCLES cycles.
  - c_in may settle up to HOLD_CYCLES-1 cycles after a vector change and still be sampled correctly.
  - done rises exactly 4*HOLD_CYCLES rising edges after the edge that accepted start.
- start while in DRIVE or FIN is ignored; no restart and no queuing.
- start held high continuously: a new run is accepted on the first edge back in IDLE, i.e. back-to-back runs with a 1-cycle IDLE gap after FIN.
- mismatch and done coincide only on the vector-3 sample edge.

Test Plan:
- HOLD_CYCLES=5, c_in = a_out | b_out (loopback model), 1-cycle start -> vectors 11, 10, 01, 00 for 5 cycles each; done 20 edges after start; mismatch never pulses; err_cnt = 0; pass = 1.
- c_in tied 0 -> mismatch pulses at the sample edges of vec 0, 1, 2 only; done with err_cnt = 3, pass = 0.
- c_in = a_out & b_out -> mismatches on vec 1 and vec 2; err_cnt = 2, pass = 0. Then loopback c_in and restart -> err_cnt clears to 0 at start, final pass = 1.
- ERR_W=1, c_in tied 0 -> err_cnt saturates at 1 (no wrap to 0); pass = 0.
- Pulse start again during vec 1, and hold start high through FIN -> mid-run pulse ignored (vec_idx sequence unchanged); second run begins one cycle after done.
- Assert rst_n low asynchronously during vec 2, between clock edges -> a_out = b_out = busy = 0 immediately; no done pulse; err_cnt = 0; next start runs from vec 0.
